hdmi_video_timing: RTL and testbench

Raster timing generator for the HDMI output path. It produces the pixel coordinates and active-video flag that drive `hdmi_pixel_colour`. It takes that block's registered RGB back and delays its own sync/DE signals to match the colour pipeline. It presents an aligned `{hs, vs, de, rgb}` bundle to the HDMI transmitter pins.

---
 rtl/hdmi_video_timing.sv | 117 +++++++++++
 tb/tb_hdmi_video_timing.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: raster timing generator that aligns sync/DE with the colour pipeline
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   px_x, px_y                presented raster position (to the colour block)
//   data_en                   presented position lies in the active area
//   frame_start               one-cycle pulse while the presented position is (0,0)
//   r, g, b                   colour for the position presented PIPE_DELAY cycles earlier
//   vid_hs, vid_vs, vid_de    sync and data enable to the transmitter
//   vid_data                  {r,g,b} to the transmitter, zero during blanking
module hdmi_video_timing #(
   parameter int   H_ACTIVE   = 1280,
   parameter int   H_FP       = 48,
   parameter int   H_SYNC     = 112,
   parameter int   H_BP       = 248,
   parameter int   V_ACTIVE   = 1024,
   parameter int   V_FP       = 1,
   parameter int   V_SYNC     = 3,
   parameter int   V_BP       = 38,
   parameter logic HS_POL     = 1'b1,
   parameter logic VS_POL     = 1'b1,
   parameter int   PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] px_x,
   output logic [11:0] px_y,
   output logic        data_en,
   output logic        frame_start,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        vid_hs,
   output logic        vid_vs,
   output logic        vid_de,
   output logic [23:0] vid_data
);
   localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] HA     = 12'(H_ACTIVE);
   localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VA     = 12'(V_ACTIVE);
   localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [11:0] h_q, h_d, v_q, v_d;
   logic        de_q, de_d, fs_q, fs_d;
   logic [2:0]  raw, dly;
   logic        hs_q, vs_q, vde_q;
   logic [23:0] data_q;

   // data_en and frame_start are decoded from the next position so they
   // register alongside h/v and always describe the presented position
   always_comb begin
      h_d  = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
      v_d  = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      de_d = (h_d < HA) && (v_d < VA);
      fs_d = (h_d == 12'd0) && (v_d == 12'd0);
      raw  = {de_q, (h_q >= HS_ON) && (h_q < HS_OFF), (v_q >= VS_ON) && (v_q < VS_OFF)};
   end

   // reset parks on the last raster position so the first free edge lands on (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q  <= H_LAST;
         v_q  <= V_LAST;
         de_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         de_q <= de_d;
         fs_q <= fs_d;
      end
   end

   // {de, hs, vs} travel together so they keep their raw relative phase
   generate
      if (PIPE_DELAY == 0) begin : g_bypass
         assign dly = raw;
      end else begin : g_pipe
         logic [2:0] sr_q [PIPE_DELAY];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < PIPE_DELAY; i++) sr_q[i] <= 3'b0;
            end else begin
               sr_q[0] <= raw;
               for (int i = 1; i < PIPE_DELAY; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign dly = sr_q[PIPE_DELAY-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         vde_q  <= 1'b0;
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         data_q <= 24'h0;
      end else begin
         vde_q  <= dly[2];
         hs_q   <= dly[1] ? HS_POL : ~HS_POL;
         vs_q   <= dly[0] ? VS_POL : ~VS_POL;
         data_q <= dly[2] ? {r, g, b} : 24'h0;
      end
   end

   assign px_x        = h_q;
   assign px_y        = v_q;
   assign data_en     = de_q;
   assign frame_start = fs_q;
   assign vid_hs      = hs_q;
   assign vid_vs      = vs_q;
   assign vid_de      = vde_q;
   assign vid_data    = data_q;
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: randomized self-checking bench against a cycle-count raster model
module tb_hdmi_video_timing;
   typedef struct packed {
      int ha; int hfp; int hsy; int hbp; int va; int vfp; int vsy; int vbp; int pd;
   } tim_t;
   localparam tim_t TD = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1};
   localparam tim_t TS = '{8, 1, 2, 1, 4, 1, 1, 1, 0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [23:0] rgb_d, rgb_s;
   logic [11:0] d_px_x, d_px_y, s_px_x, s_px_y;
   logic d_de, d_fs, d_vhs, d_vvs, d_vde, s_de, s_fs, s_vhs, s_vvs, s_vde;
   logic [23:0] d_vdata, s_vdata;
   int checks = 0;
   int errors = 0;
   int idx_d, idx_s;

   always #5 clk = ~clk;

   hdmi_video_timing u_def (
      .clk(clk), .rst(rst), .px_x(d_px_x), .px_y(d_px_y), .data_en(d_de), .frame_start(d_fs),
      .r(rgb_d[23:16]), .g(rgb_d[15:8]), .b(rgb_d[7:0]),
      .vid_hs(d_vhs), .vid_vs(d_vvs), .vid_de(d_vde), .vid_data(d_vdata)
   );

   hdmi_video_timing #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)
   ) u_sml (
      .clk(clk), .rst(rst), .px_x(s_px_x), .px_y(s_px_y), .data_en(s_de), .frame_start(s_fs),
      .r(rgb_s[23:16]), .g(rgb_s[15:8]), .b(rgb_s[7:0]),
      .vid_hs(s_vhs), .vid_vs(s_vvs), .vid_de(s_vde), .vid_data(s_vdata)
   );

   // Model: idx counts presented positions since reset release (-1 = reset state)
   function automatic int htot(tim_t t);
      return t.ha + t.hfp + t.hsy + t.hbp;
   endfunction

   function automatic int vtot(tim_t t);
      return t.va + t.vfp + t.vsy + t.vbp;
   endfunction

   function automatic int pos_x(tim_t t, int idx);
      return idx < 0 ? htot(t) - 1 : idx % htot(t);
   endfunction

   function automatic int pos_y(tim_t t, int idx);
      return idx < 0 ? vtot(t) - 1 : (idx / htot(t)) % vtot(t);
   endfunction

   // {de, hs, vs} of position idx; anything before the reset state is idle
   function automatic logic [2:0] raw_f(tim_t t, int idx);
      int x, y;
      if (idx < -1) return 3'b000;
      x = pos_x(t, idx);
      y = pos_y(t, idx);
      return {x < t.ha && y < t.va,
              x >= t.ha + t.hfp && x < t.ha + t.hfp + t.hsy,
              y >= t.va + t.vfp && y < t.va + t.vfp + t.vsy};
   endfunction

   // {px_x, px_y, data_en, frame_start, vid_hs, vid_vs, vid_de, vid_data}
   function automatic logic [51:0] exp_f(tim_t t, int idx, logic [23:0] rgb);
      logic [2:0] c, d;
      c = raw_f(t, idx);
      d = raw_f(t, idx - t.pd - 1);
      return {12'(pos_x(t, idx)), 12'(pos_y(t, idx)), c[2],
              idx >= 0 && pos_x(t, idx) == 0 && pos_y(t, idx) == 0,
              d[1], d[0], d[2], d[2] ? rgb : 24'h0};
   endfunction

   task automatic step(input logic rv);
      rst = rv;
      @(posedge clk);
      idx_d = rv ? -1 : idx_d + 1;
      idx_s = rv ? -1 : idx_s + 1;
      #1;
   endtask

   task automatic test_reset;
      rgb_d = $urandom;
      rgb_s = $urandom;
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         checks++;
         if ({d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata} !==
             {12'd1687, 12'd1065, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_def: got %h/%h de=%b fs=%b hs=%b vs=%b vde=%b data=%h, expected 697/429 and all zero",
                     d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata);
         end
         checks++;
         if ({s_px_x, s_px_y, s_de, s_fs, s_vhs, s_vvs, s_vde, s_vdata} !==
             {12'd11, 12'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_sml: got %0d/%0d de=%b fs=%b hs=%b vs=%b vde=%b data=%h, expected 11/6 and all zero",
                     s_px_x, s_px_y, s_de, s_fs, s_vhs, s_vvs, s_vde, s_vdata);
         end
      end
      step(1'b0);
      checks++;
      if ({d_px_x, d_px_y, d_de, d_fs} !== {12'd0, 12'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL release_def: got %0d/%0d de=%b fs=%b, expected 0/0 de=1 fs=1", d_px_x, d_px_y, d_de, d_fs);
      end
      checks++;
      if ({s_px_x, s_px_y, s_de, s_fs} !== {12'd0, 12'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL release_sml: got %0d/%0d de=%b fs=%b, expected 0/0 de=1 fs=1", s_px_x, s_px_y, s_de, s_fs);
      end
   endtask

   task automatic test_line_timing;
      logic [51:0] e;
      int n_de = 0, n_hs = 0, n_fs = 0, rise = -1;
      logic prev = 1'b0;
      step(1'b1);
      for (int i = 0; i < 3 * 1688; i++) begin
         rgb_d = $urandom;
         step(1'b0);
         e = exp_f(TD, idx_d, rgb_d);
         checks++;
         if ({d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata} !== e) begin
            errors++;
            $display("FAIL line_cycle idx=%0d: got %h expected %h", idx_d,
                     {d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata}, e);
         end
         n_de += int'(d_de);
         n_hs += int'(d_vhs);
         n_fs += int'(d_fs);
         if (d_vhs && !prev && rise < 0) rise = idx_d;
         prev = d_vhs;
      end
      checks++;
      if (n_de != 3 * 1280) begin
         errors++;
         $display("FAIL line_de_count: got %0d expected %0d", n_de, 3 * 1280);
      end
      checks++;
      if (n_hs != 3 * 112) begin
         errors++;
         $display("FAIL line_hs_count: got %0d expected %0d", n_hs, 3 * 112);
      end
      checks++;
      if (rise != 1330) begin
         errors++;
         $display("FAIL line_hs_rise: got idx %0d expected 1330", rise);
      end
      checks++;
      if (n_fs != 1) begin
         errors++;
         $display("FAIL line_fs_count: got %0d expected 1", n_fs);
      end
   endtask

   task automatic test_pipeline;
      logic [23:0] e;
      logic [2:0] c;
      logic first = 1'b1;
      step(1'b1);
      for (int i = 0; i < 2 * 1688 + 10; i++) begin
         rgb_d = {8'(pos_x(TD, idx_d - 1)), 8'(pos_y(TD, idx_d - 1)), 8'hA5};
         step(1'b0);
         c = raw_f(TD, idx_d - 2);
         e = c[2] ? {8'(pos_x(TD, idx_d - 2)), 8'(pos_y(TD, idx_d - 2)), 8'hA5} : 24'h0;
         checks++;
         if ({d_vde, d_vdata} !== {c[2], e}) begin
            errors++;
            $display("FAIL pipe_align idx=%0d: got de=%b data=%h expected de=%b data=%h", idx_d, d_vde, d_vdata, c[2], e);
         end
         if (d_vde && first) begin
            first = 1'b0;
            checks++;
            if (d_vdata !== 24'h0000A5) begin
               errors++;
               $display("FAIL pipe_first: got %h expected 0000a5", d_vdata);
            end
         end
      end
   endtask

   task automatic test_small_frames;
      logic [51:0] e;
      int n_vde = 0, n_fs = 0, n_vs = 0;
      step(1'b1);
      for (int i = 0; i < 2 * 84; i++) begin
         rgb_s = $urandom;
         rgb_d = $urandom;
         step(1'b0);
         e = exp_f(TS, idx_s, rgb_s);
         checks++;
         if ({s_px_x, s_px_y, s_de, s_fs, s_vhs, s_vvs, s_vde, s_vdata} !== e) begin
            errors++;
            $display("FAIL small_cycle idx=%0d: got %h expected %h", idx_s,
                     {s_px_x, s_px_y, s_de, s_fs, s_vhs, s_vvs, s_vde, s_vdata}, e);
         end
         n_vde += int'(s_vde);
         n_fs  += int'(s_fs);
         n_vs  += int'(s_vvs);
      end
      checks++;
      if (n_vde != 64) begin
         errors++;
         $display("FAIL small_vde_count: got %0d expected 64", n_vde);
      end
      checks++;
      if (n_fs != 2) begin
         errors++;
         $display("FAIL small_fs_count: got %0d expected 2", n_fs);
      end
      checks++;
      if (n_vs != 24) begin
         errors++;
         $display("FAIL small_vs_count: got %0d expected 24", n_vs);
      end
   endtask

   task automatic test_midframe_reset;
      logic [51:0] e;
      int targets [2];
      int n_hs, early;
      targets[0] = 2 * 1688 + 500;
      targets[1] = 1688 + 1330 + int'($urandom_range(0, 100));
      foreach (targets[t]) begin
         step(1'b1);
         step(1'b0);
         while (idx_d < targets[t]) begin
            rgb_d = $urandom;
            step(1'b0);
         end
         checks++;
         if ({d_px_x, d_px_y} !== {12'(pos_x(TD, targets[t])), 12'(pos_y(TD, targets[t]))}) begin
            errors++;
            $display("FAIL mid_position: got %0d/%0d expected %0d/%0d", d_px_x, d_px_y,
                     pos_x(TD, targets[t]), pos_y(TD, targets[t]));
         end
         step(1'b1);
         checks++;
         if ({d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata} !==
             {12'd1687, 12'd1065, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL mid_reset_values: got %0d/%0d de=%b fs=%b hs=%b vs=%b vde=%b data=%h",
                     d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata);
         end
         n_hs = 0;
         early = 0;
         for (int i = 0; i < 1700; i++) begin
            rgb_d = $urandom;
            step(1'b0);
            e = exp_f(TD, idx_d, rgb_d);
            checks++;
            if ({d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata} !== e) begin
               errors++;
               $display("FAIL mid_cycle idx=%0d: got %h expected %h", idx_d,
                        {d_px_x, d_px_y, d_de, d_fs, d_vhs, d_vvs, d_vde, d_vdata}, e);
            end
            if (i == 0) begin
               checks++;
               if ({d_px_x, d_px_y, d_fs} !== {12'd0, 12'd0, 1'b1}) begin
                  errors++;
                  $display("FAIL mid_restart: got %0d/%0d fs=%b expected 0/0 fs=1", d_px_x, d_px_y, d_fs);
               end
            end
            n_hs += int'(d_vhs);
            if (idx_d < 1330) early += int'(d_vhs);
         end
         checks++;
         if (early != 0 || n_hs != 112) begin
            errors++;
            $display("FAIL mid_hs_after_reset: got early=%0d total=%0d expected early=0 total=112", early, n_hs);
         end
      end
   endtask

   initial begin
      rgb_d = 24'h0;
      rgb_s = 24'h0;
      test_reset;
      test_line_timing;
      test_pipeline;
      test_small_frames;
      test_midframe_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
